// File: rtl/gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctrl.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctrl.sv - scan chain load/capture/unload sequencer
// Optional unload compare enabled by GF180MCU_SCAN_CHAIN_CTRL_COMPARE_EN.
module gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctrl #(
  parameter int CHAIN_LEN = 8
) (
  input  logic                 CLK,
  input  logic                 RN,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT,
  input  logic [CHAIN_LEN-1:0] EXP,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] CAP_DATA,
  output logic                 FAIL
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, CAPTURE, UNLOAD, FIN} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] pat_sr;
  logic [CHAIN_LEN-1:0] cap_next;

  // First unloaded bit walks down to index 0 after CHAIN_LEN shifts.
  assign cap_next = {SO, CAP_DATA[CHAIN_LEN-1:1]};

`ifdef GF180MCU_SCAN_CHAIN_CTRL_COMPARE_EN
  logic [CHAIN_LEN-1:0] exp_q;
`else
  logic unused_exp;
  assign unused_exp = ^EXP;
  assign FAIL = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state    <= IDLE;
      cnt      <= '0;
      pat_sr   <= '0;
      SE       <= 1'b0;
      SI       <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      CAP_DATA <= '0;
`ifdef GF180MCU_SCAN_CHAIN_CTRL_COMPARE_EN
      exp_q    <= '0;
      FAIL     <= 1'b0;
`endif
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            state    <= SHIFT;
            cnt      <= '0;
            pat_sr   <= PAT >> 1;
            SI       <= PAT[0];
            SE       <= 1'b1;
            BUSY     <= 1'b1;
            CAP_DATA <= '0;
`ifdef GF180MCU_SCAN_CHAIN_CTRL_COMPARE_EN
            exp_q    <= EXP;
            FAIL     <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          if (cnt == LAST) begin
            state <= CAPTURE;
            cnt   <= '0;
            SE    <= 1'b0;
            SI    <= 1'b0;
          end else begin
            cnt    <= cnt + 1'b1;
            pat_sr <= pat_sr >> 1;
            SI     <= pat_sr[0];
          end
        end
        CAPTURE: begin
          state <= UNLOAD;
          SE    <= 1'b1;
          SI    <= 1'b0;
        end
        UNLOAD: begin
          CAP_DATA <= cap_next;
          if (cnt == LAST) begin
            state <= FIN;
            cnt   <= '0;
            SE    <= 1'b0;
            DONE  <= 1'b1;
`ifdef GF180MCU_SCAN_CHAIN_CTRL_COMPARE_EN
            FAIL  <= (cap_next != exp_q);
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          SE    <= 1'b0;
          SI    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctrl.sv
// tb/tb_gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctrl.sv - directed bench with behavioural scan chains
// Expectations for FAIL follow GF180MCU_SCAN_CHAIN_CTRL_COMPARE_EN.
module tb_gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctrl;

  logic CLK = 1'b0;
  logic RN  = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic       st8 = 1'b0;
  logic [7:0] pat8 = '0, exp8 = '0, cap8;
  logic       so8, se8, si8, busy8, done8, fail8;
  logic [7:0] cells8 = '0;
  logic       cap_mode = 1'b0;
  logic [7:0] cap_val = '0;

  logic       st2 = 1'b0;
  logic [1:0] pat2 = '0, cap2;
  logic       so2, se2, si2, busy2, done2, fail2;
  logic [1:0] cells2 = '0;

  logic        st64 = 1'b0;
  logic [63:0] pat64 = '0, cap64;
  logic        so64, se64, si64, busy64, done64, fail64;
  logic [63:0] cells64 = '0;

  gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctrl #(.CHAIN_LEN(8)) dut8 (
    .CLK(CLK), .RN(RN), .START(st8), .PAT(pat8), .EXP(exp8), .SO(so8),
    .SE(se8), .SI(si8), .BUSY(busy8), .DONE(done8), .CAP_DATA(cap8), .FAIL(fail8));
  gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctrl #(.CHAIN_LEN(2)) dut2 (
    .CLK(CLK), .RN(RN), .START(st2), .PAT(pat2), .EXP(pat2), .SO(so2),
    .SE(se2), .SI(si2), .BUSY(busy2), .DONE(done2), .CAP_DATA(cap2), .FAIL(fail2));
  gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctrl #(.CHAIN_LEN(64)) dut64 (
    .CLK(CLK), .RN(RN), .START(st64), .PAT(pat64), .EXP(pat64), .SO(so64),
    .SE(se64), .SI(si64), .BUSY(busy64), .DONE(done64), .CAP_DATA(cap64), .FAIL(fail64));

  // Capture data bit k lands in the cell that unloads k-th, i.e. cell 7-k.
  function automatic logic [7:0] rev8(input logic [7:0] v);
    for (int k = 0; k < 8; k++) rev8[7-k] = v[k];
  endfunction

  assign so8  = cells8[7];
  assign so2  = cells2[1];
  assign so64 = cells64[63];

  always @(posedge CLK) begin
    if (se8) cells8 <= {cells8[6:0], si8};
    else if (cap_mode) cells8 <= rev8(cap_val);
    if (se2) cells2 <= {cells2[0], si2};
    if (se64) cells64 <= {cells64[62:0], si64};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic run8(input logic [7:0] pat, input logic [7:0] expv, input logic cmode,
                      input logic [7:0] cval, input logic [7:0] want_cap);
    logic want_fail;
`ifdef GF180MCU_SCAN_CHAIN_CTRL_COMPARE_EN
    want_fail = (want_cap != expv);
`else
    want_fail = 1'b0;
`endif
    pat8 = pat; exp8 = expv; cap_mode = cmode; cap_val = cval;
    st8 = 1'b1;
    tick;
    st8 = 1'b0;
    check("cap_clr_e0", cap8, 8'h00);
    for (int c = 0; c <= 18; c++) begin
      check($sformatf("se_c%0d", c), se8, ((c < 8) || (c >= 9 && c <= 16)) ? 1 : 0);
      check($sformatf("si_c%0d", c), si8, (c < 8) ? pat[c] : 1'b0);
      check($sformatf("busy_c%0d", c), busy8, (c <= 17) ? 1 : 0);
      check($sformatf("done_c%0d", c), done8, (c == 17) ? 1 : 0);
      check($sformatf("fail_c%0d", c), fail8, (c >= 17) ? want_fail : 1'b0);
      if (c == 17) check("cap_fin", cap8, want_cap);
      if (c < 18) tick;
    end
    for (int i = 0; i < 3; i++) tick;
    check("cap_hold", cap8, want_cap);
    check("fail_hold", fail8, want_fail);
  endtask

  initial begin
    int n;
    int dones;
    RN = 1'b0;
    tick; tick;
    check("rst_se", se8, 0);
    check("rst_si", si8, 0);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_cap", cap8, 0);
    check("rst_fail", fail8, 0);
    check("rst_busy64", busy64, 0);
    RN = 1'b1;
    tick;

    run8(8'hA5, 8'hA5, 1'b0, 8'h00, 8'hA5);
    run8(8'h5A, 8'h00, 1'b0, 8'h00, 8'h5A);
    run8(8'hFF, 8'h3C, 1'b1, 8'h3C, 8'h3C);
    run8(8'hFF, 8'h3D, 1'b1, 8'h3C, 8'h3C);
    cap_mode = 1'b0;

    // START held through a whole sequence and into the following IDLE cycle.
    pat8 = 8'h96; exp8 = 8'h96;
    st8 = 1'b1;
    tick;
    dones = 0;
    for (int c = 0; c <= 18; c++) begin
      if (done8) dones++;
      if (c == 18) check("hold_idle_busy", busy8, 0);
      if (c < 18) tick;
    end
    check("hold_done_once", dones, 1);
    check("hold_cap", cap8, 8'h96);
    tick;
    check("hold_restart_busy", busy8, 1);
    check("hold_restart_se", se8, 1);
    check("hold_restart_cap", cap8, 0);
    st8 = 1'b0;
    n = 0;
    while (busy8 && n < 100) begin tick; n++; end
    check("hold_second_end", busy8, 0);

    // Reset during unload cycle 3, with START asserted at the reset edge.
    pat8 = 8'hC3;
    st8 = 1'b1;
    tick;
    st8 = 1'b0;
    for (int c = 1; c <= 12; c++) tick;
    check("pre_rst_se", se8, 1);
    RN = 1'b0; st8 = 1'b1;
    tick;
    RN = 1'b1; st8 = 1'b0;
    check("abort_se", se8, 0);
    check("abort_busy", busy8, 0);
    check("abort_cap", cap8, 0);
    check("abort_done", done8, 0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (done8 || busy8) dones++;
    end
    check("abort_stays_idle", dones, 0);

    pat2 = 2'b10;
    st2 = 1'b1;
    tick;
    st2 = 1'b0;
    n = 0;
    while (!done2 && n < 300) begin tick; n++; end
    check("len2_done_edge", n, 5);
    check("len2_cap", cap2, 2'b10);
    tick;

    pat64 = {$urandom, $urandom};
    st64 = 1'b1;
    tick;
    st64 = 1'b0;
    n = 0;
    while (!done64 && n < 300) begin tick; n++; end
    check("len64_done_edge", n, 129);
    check("len64_cap", cap64, pat64);
    check("len64_fail", fail64, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctrl.md
GF180MCU_FD_SC_MCU9T5V0__SCAN_CHAIN_CTRL -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__scan_chain_ctrl

Interface
REQ-001 Parameter: CHAIN_LEN, 8, number of scan cells in the driven chain (legal 2..64).
REQ-002 Parameter: CNT_W, $clog2(CHAIN_LEN+1), shift counter width (derived, not overridden).
REQ-003 CLK  input  1  rising-edge clock; the only clock.
REQ-004 RN  input  1  reset, synchronous, active-low.
REQ-005 START  input  1  request one load/capture/unload test sequence.
REQ-006 PAT  input  CHAIN_LEN  pattern to shift in.
REQ-007 EXP  input  CHAIN_LEN  expected unload data.
REQ-008 SO  input  1  scan-out of the last chain cell.
REQ-009 SE  output  1  scan enable to every cell of the chain.
REQ-010 SI  output  1  scan-in to the first chain cell.
REQ-011 BUSY  output  1  sequence in progress.
REQ-012 DONE  output  1  one-cycle completion pulse.
REQ-013 CAP_DATA  output  CHAIN_LEN  unloaded chain contents.
REQ-014 FAIL  output  1  CAP_DATA differs from EXP.

Function
REQ-015 Chain model: cell 0 fed by SI, cell CHAIN_LEN-1 drives SO; SE=1 shifts, SE=0 captures D.
REQ-016 FSM states IDLE, SHIFT, CAPTURE, UNLOAD, FIN; IDLE is the reset state.
REQ-017 START is sampled only in IDLE; PAT and EXP are latched at that edge (E0); START in any other state is ignored.
REQ-018 SHIFT lasts exactly CHAIN_LEN cycles (E0..E_L); SE=1; in shift cycle k (k=0 first), SI=latched PAT[k].
REQ-019 CAPTURE lasts exactly one cycle (E_L..E_L+1); SE=0, SI=0.
REQ-020 UNLOAD lasts exactly CHAIN_LEN cycles; SE=1, SI=0; CAP_DATA[k] = SO sampled at the edge ending unload cycle k.
REQ-021 FIN lasts one cycle (E_2L+1..E_2L+2) with DONE=1, SE=0; next state is IDLE unconditionally.
REQ-022 BUSY=1 in SHIFT, CAPTURE, UNLOAD and FIN; 0 in IDLE.
REQ-023 With capture leaving every cell unchanged, CAP_DATA equals PAT (loopback identity).
REQ-024 CAP_DATA and FAIL hold their values from FIN until the next accepted START, then clear to 0 at E0.
REQ-025 Shift counter counts 0..CHAIN_LEN-1 in SHIFT and UNLOAD and wraps to 0 on each state exit; no other value is reached.
REQ-026 A START asserted in FIN is ignored; a START in the following IDLE cycle is accepted.

Reset
REQ-027 On a CLK edge with RN=0: state=IDLE, SE=0, SI=0, BUSY=0, DONE=0, CAP_DATA=0, FAIL=0, counter=0.
REQ-028 RN=0 mid-sequence aborts at that edge with no DONE pulse; START sampled while RN=0 is ignored.

Configuration
REQ-029 Macro GF180MCU_SCAN_CHAIN_CTRL_COMPARE_EN defined: FAIL set at the FIN entry edge iff CAP_DATA != latched EXP.
REQ-030 Macro undefined: FAIL tied 0, EXP unused, no compare logic.

Verification
REQ-031 CHAIN_LEN=8, loopback chain model, PAT=8'hA5, START pulse -> SE=1 8 cycles, SE=0 1 cycle, SE=1 8 cycles, DONE at E17, CAP_DATA=8'hA5.
REQ-032 Capture model loads 8'h3C, PAT=8'hFF -> CAP_DATA=8'h3C; with COMPARE_EN and EXP=8'h3C FAIL=0, with EXP=8'h3D FAIL=1.
REQ-033 START held high through a whole sequence -> exactly one sequence, DONE once, new sequence begins at first IDLE edge after FIN.
REQ-034 RN=0 for one edge during UNLOAD cycle 3 -> next cycle IDLE, SE=0, BUSY=0, CAP_DATA=0, no DONE.
REQ-035 CHAIN_LEN=2 and CHAIN_LEN=64, random PAT loopback -> DONE at E(2*CHAIN_LEN+1), CAP_DATA=PAT.
REQ-036 Macro undefined, mismatching EXP -> FAIL stays 0 in every cycle.
